adder_accumulator: RTL and testbench

//   Downstream consumer of serial_adder: captures each {cout, s} result under a

---
 rtl/adder_accumulator.sv | 95 +++++++++
 tb/tb_adder_accumulator.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_accumulator.sv
// rtl/adder_accumulator.sv - sums COUNT serial_adder results per frame behind valid/ready handshakes
module adder_accumulator #(
    parameter int WIDTH = 32,
    parameter int COUNT = 4,
    localparam int ACC_W = WIDTH + 1 + $clog2(COUNT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_s,
    input  logic             in_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum
);

    // Beat counter must be able to hold the value COUNT itself.
    localparam int CNT_W = $clog2(COUNT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic [ACC_W-1:0] beat;
    logic [ACC_W-1:0] sum_next;
    logic [CNT_W-1:0] cnt_next;
    logic             in_fire;
    logic             last_beat;

    // The carry-out is the top bit of the beat; the rest of the accumulator width is headroom.
    assign beat      = ACC_W'({in_cout, in_s});
    // Ready depends on state alone so upstream never sees a combinational path from in_valid.
    assign in_ready  = (state != HOLD);
    assign in_fire   = in_valid && in_ready;
    // IDLE starts a fresh frame, so the running sum and count restart from this beat.
    assign sum_next  = (state == IDLE) ? beat : acc + beat;
    assign cnt_next  = (state == IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
    assign last_beat = (cnt_next == CNT_W'(COUNT));

    // Frame FSM: accumulate beats, then hold the registered total until it is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
        end else if (clear) begin
            // Abort wins over any same-cycle beat or transfer; the last total stays visible.
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (in_fire) begin
                        acc <= sum_next;
                        cnt <= cnt_next;
                        if (last_beat) begin
                            state     <= HOLD;
                            out_sum   <= sum_next;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        acc       <= '0;
                        cnt       <= '0;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    acc       <= '0;
                    cnt       <= '0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_accumulator.sv
// tb/tb_adder_accumulator.sv - self-checking bench for adder_accumulator (COUNT=4 and COUNT=1)
module tb_adder_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_s = 8'h00;
    logic       in_cout = 1'b0;
    logic       out_ready = 1'b0;

    logic        in_ready0, out_valid0;
    logic [10:0] out_sum0;
    logic        in_ready1, out_valid1;
    logic [8:0]  out_sum1;

    int total = 0;
    int bad = 0;

    // Reference model: beats seen in the open frame, their sum, and the last emitted total.
    bit m_hold[2];
    int m_n[2];
    int m_sum[2];
    int m_tot[2];

    adder_accumulator #(.WIDTH(8), .COUNT(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready0), .in_s(in_s), .in_cout(in_cout),
        .out_valid(out_valid0), .out_ready(out_ready), .out_sum(out_sum0)
    );

    adder_accumulator #(.WIDTH(8), .COUNT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready1), .in_s(in_s), .in_cout(in_cout),
        .out_valid(out_valid1), .out_ready(out_ready), .out_sum(out_sum1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_rdy0"}, 32'(in_ready0), 32'(!m_hold[0]));
        chk({tag, "_vld0"}, 32'(out_valid0), 32'(m_hold[0]));
        chk({tag, "_sum0"}, 32'(out_sum0), 32'(m_tot[0]));
        chk({tag, "_rdy1"}, 32'(in_ready1), 32'(!m_hold[1]));
        chk({tag, "_vld1"}, 32'(out_valid1), 32'(m_hold[1]));
        chk({tag, "_sum1"}, 32'(out_sum1), 32'(m_tot[1]));
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_hold[k] = 1'b0;
            m_n[k]    = 0;
            m_sum[k]  = 0;
            m_tot[k]  = 0;
        end
    endtask

    // One clock: check outputs at the falling edge, drive the next inputs, advance the model.
    task automatic cyc(input string tag, input bit iv, input bit co, input logic [7:0] s,
                       input bit ordy, input bit clr);
        int frame_len;
        @(negedge clk);
        check_all(tag);
        in_valid  = iv;
        in_cout   = co;
        in_s      = s;
        out_ready = ordy;
        clear     = clr;
        for (int k = 0; k < 2; k++) begin
            frame_len = (k == 0) ? 4 : 1;
            if (clr) begin
                m_hold[k] = 1'b0;
                m_n[k]    = 0;
                m_sum[k]  = 0;
            end else if (m_hold[k]) begin
                if (ordy) begin
                    m_hold[k] = 1'b0;
                    m_n[k]    = 0;
                    m_sum[k]  = 0;
                end
            end else if (iv) begin
                m_sum[k] = m_sum[k] + int'({co, s});
                m_n[k]   = m_n[k] + 1;
                if (m_n[k] == frame_len) begin
                    m_tot[k]  = m_sum[k];
                    m_hold[k] = 1'b1;
                end
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        model_reset();
        #12;
        chk("reset_vld0", 32'(out_valid0), 32'd0);
        chk("reset_sum0", 32'(out_sum0), 32'd0);
        chk("reset_vld1", 32'(out_valid1), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_rdy0", 32'(in_ready0), 32'd1);

        // Basic frame 1+2+3+4
        for (int i = 1; i <= 4; i++) cyc("basic", 1'b1, 1'b0, 8'(i), 1'b1, 1'b0);
        #1;
        chk("basic_sum", 32'(out_sum0), 32'h00A);
        chk("basic_vld", 32'(out_valid0), 32'd1);
        idle("basic_idle", 2);
        #1;
        chk("basic_done_vld", 32'(out_valid0), 32'd0);

        // Maximum beats, no wrap
        for (int i = 0; i < 4; i++) cyc("max", 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
        #1;
        chk("max_sum", 32'(out_sum0), 32'h7FC);
        idle("max_idle", 2);

        // Back-pressure: out_ready low for 5 cycles in HOLD while upstream keeps offering
        for (int i = 0; i < 4; i++) cyc("bp_fill", 1'b1, 1'b0, 8'h05, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc("bp_hold", 1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
        #1;
        chk("bp_rdy", 32'(in_ready0), 32'd0);
        chk("bp_sum", 32'(out_sum0), 32'h014);
        cyc("bp_xfer", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        idle("bp_idle", 2);

        // Gapped input
        for (int i = 0; i < 8; i++) cyc("gap", (i % 2) == 0, 1'b0, 8'h10, 1'b1, 1'b0);
        #1;
        chk("gap_sum", 32'(out_sum0), 32'h040);
        idle("gap_idle", 2);

        // Clear mid-frame, then a full frame
        cyc("clr_a", 1'b1, 1'b0, 8'h07, 1'b1, 1'b0);
        cyc("clr_b", 1'b1, 1'b0, 8'h07, 1'b1, 1'b0);
        cyc("clr_c", 1'b1, 1'b0, 8'h07, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cyc("clr_frame", 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
        #1;
        chk("clr_sum", 32'(out_sum0), 32'h004);
        idle("clr_idle", 1);

        // Clear while holding a total
        for (int i = 0; i < 4; i++) cyc("clrh_fill", 1'b1, 1'b0, 8'h02, 1'b0, 1'b0);
        cyc("clrh_hold", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc("clrh_clr", 1'b1, 1'b0, 8'h09, 1'b1, 1'b1);
        #1;
        chk("clrh_vld", 32'(out_valid0), 32'd0);
        chk("clrh_sum", 32'(out_sum0), 32'h008);
        idle("clrh_idle", 1);

        // Asynchronous reset after 3 beats, then a clean frame
        for (int i = 0; i < 3; i++) cyc("rst_part", 1'b1, 1'b0, 8'h11, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_vld0", 32'(out_valid0), 32'd0);
        chk("rst_mid_sum0", 32'(out_sum0), 32'd0);
        chk("rst_mid_sum1", 32'(out_sum1), 32'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 4; i++) cyc("rst_new", 1'b1, 1'b0, 8'h03, 1'b1, 1'b0);
        #1;
        chk("rst_new_sum", 32'(out_sum0), 32'h00C);
        idle("rst_idle", 1);

        // COUNT=1 instance: each {1,0x00} beat totals 0x100
        cyc("c1_beat", 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
        #1;
        chk("c1_sum", 32'(out_sum1), 32'h100);
        chk("c1_vld", 32'(out_valid1), 32'd1);
        idle("c1_idle", 2);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc("rand", $urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom),
                $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
        end
        idle("final", 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
